// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch to imem, in-order buffering, redirect flush.
// Optional same-cycle response bypass to decode when INST_PREFETCH_BYPASS_EN is defined.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d;
  logic [31:0]     q_data_q [DEPTH];
  logic [31:0]     q_pc_q   [DEPTH];
  logic [31:0]     tag_q    [DEPTH];

  logic        credit_ok;
  logic        req_fire;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] rsp_tag;

  // Credit counts both in-flight requests and buffered entries so the queue cannot overflow.
  assign credit_ok      = ({1'b0, out_cnt_q} + {1'b0, count_q}) < SW'(DEPTH);
  assign imem_req_valid = (state_q == ST_RUN) && credit_ok && !redirect;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_tag        = tag_q[tag_rd_q];

`ifdef INST_PREFETCH_BYPASS_EN
  assign bypass     = (count_q == '0) && (discard_q == '0) && !redirect && imem_rsp_valid;
  assign inst_valid = bypass || (count_q != '0);
  assign inst       = bypass ? imem_rsp_data : q_data_q[head_q];
  assign inst_pc    = bypass ? rsp_tag : q_pc_q[head_q];
`else
  assign bypass     = 1'b0;
  assign inst_valid = (count_q != '0);
  assign inst       = q_data_q[head_q];
  assign inst_pc    = q_pc_q[head_q];
`endif

  // A bypassed response taken by decode never touches the queue.
  assign pop  = (count_q != '0) && inst_ready;
  assign push = imem_rsp_valid && (discard_q == '0) && !redirect && !(bypass && inst_ready);

  // Next-state logic; redirect overrides every other queue/fetch update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q;
    count_d    = count_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;

    if (state_q == ST_IDLE) state_d = ST_RUN;

    if (req_fire)       tag_wr_d = tag_wr_q + PW'(1);
    if (imem_rsp_valid) tag_rd_d = tag_rd_q + PW'(1);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      out_cnt_d  = out_cnt_q - CW'(imem_rsp_valid);
      discard_d  = out_cnt_q - CW'(imem_rsp_valid);
      count_d    = '0;
      head_d     = tail_q;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      count_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  // Storage is cleared on reset so inst/inst_pc read as zero until first written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
      if (push) begin
        q_data_q[tail_q] <= imem_rsp_data;
        q_pc_q[tail_q]   <= rsp_tag;
      end
    end
  end

  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue (default build, DEPTH=4, RESET_PC=0).
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rstn;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        red;
    logic [31:0] rpc;
    logic        ir;
    logic        qv;
    logic [31:0] qa;
    logic        iv;
    logic        ci;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic        pend_v;
  logic [31:0] pend_a;
  logic        fire_v;
  logic [31:0] fire_a;
  logic        got_v;
  logic [31:0] got_pc;
  logic [31:0] got_d;

  localparam logic [31:0] D0 = 32'h0050_0113;
  localparam logic [31:0] D1 = 32'h0021_0233;
  localparam logic [31:0] D2 = 32'h1111_1111;
  localparam logic [31:0] D3 = 32'h2222_2222;
  localparam logic [31:0] D4 = 32'h3333_3333;

  function automatic vec_t mk(input logic rstn, input logic rr, input logic rv, input logic [31:0] rd,
                              input logic red, input logic [31:0] rpc, input logic ir,
                              input logic qv, input logic [31:0] qa, input logic iv, input logic ci,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t v;
    v.rstn = rstn; v.rr = rr; v.rv = rv; v.rd = rd; v.red = red; v.rpc = rpc; v.ir = ir;
    v.qv = qv; v.qa = qa; v.iv = iv; v.ci = ci; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle against a latency-1 memory model with decode always ready.
  task automatic step(input logic red_v, input logic [31:0] rpc_v);
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    imem_rsp_valid = pend_v;
    imem_rsp_data  = mem_word(pend_a);
    redirect       = red_v;
    redirect_pc    = rpc_v;
    #1;
    fire_v = imem_req_valid;
    fire_a = imem_req_addr;
    got_v  = inst_valid;
    got_pc = inst_pc;
    got_d  = inst;
    pend_v = fire_v;
    pend_a = fire_a;
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] exp_pc;
    int ndel;
    int nfire;
    bit seen;

    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    pend_v = 1'b0; pend_a = '0;

    //            rstn rr rv rd            red rpc           ir  qv qa            iv ci ins           ipc
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, D0,           0, 32'h0,   0,  1, 32'h4,   0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, D1,           0, 32'h0,   0,  1, 32'h8,   1, 1, D0,           32'h0));
    vecs.push_back(mk(1, 1, 1, D2,           0, 32'h0,   0,  1, 32'hC,   1, 1, D0,           32'h0));
    vecs.push_back(mk(1, 1, 1, D3,           0, 32'h0,   0,  0, 32'h10,  1, 1, D0,           32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  0, 32'h10,  1, 1, D0,           32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h10,  1, 1, D1,           32'h4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h14,  1, 1, D1,           32'h4));
    vecs.push_back(mk(1, 1, 1, D4,           0, 32'h0,   0,  0, 32'h14,  1, 1, D1,           32'h4));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  0, 32'h14,  1, 1, D1,           32'h4));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h14,  1, 1, D2,           32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h14,  1, 1, D3,           32'hC));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h14,  1, 1, D4,           32'h10));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h14,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h14,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h18,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h66,  1,  0, 32'h1C,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, 32'hDEAD0001, 0, 32'h0,   1,  1, 32'h64,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 1, 32'hDEAD0002, 0, 32'h0,   1,  1, 32'h68,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 1, 32'h0000A013, 0, 32'h0,   1,  1, 32'h68,  0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h68,  1, 1, 32'h0000A013, 32'h64));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h68,  1, 1, 32'h0000A013, 32'h64));
    vecs.push_back(mk(1, 1, 1, 32'hBAD00003, 1, 32'h200, 1,  0, 32'h6C,  1, 1, 32'h0000A013, 32'h64));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h200, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h200, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h204, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h55,       0, 32'h0,   0,  1, 32'h208, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h20C, 1, 1, 32'h55,       32'h200));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h210, 1, 1, 32'h55,       32'h200));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h0,   0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 0, 32'h0,        32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rstn;
      imem_req_ready = vecs[i].rr;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rd;
      redirect       = vecs[i].red;
      redirect_pc    = vecs[i].rpc;
      inst_ready     = vecs[i].ir;
      #1;
      chk($sformatf("v%0d imem_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].qv));
      chk($sformatf("v%0d imem_req_addr", i), imem_req_addr, vecs[i].qa);
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      if (vecs[i].ci) begin
        chk($sformatf("v%0d inst", i), inst, vecs[i].ins);
        chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].ipc);
      end
    end

    // Steady-state streaming from PC 0 with latency-1 memory.
    exp_pc = 32'h0;
    ndel   = 0;
    nfire  = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 32'h0);
      if (fire_v) nfire++;
      if (got_v) begin
        chk($sformatf("stream%0d inst_pc", k), got_pc, exp_pc);
        chk($sformatf("stream%0d inst", k), got_d, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
    end
    chk("stream requests", 32'(nfire), 32'd24);
    chk("stream deliveries", 32'(ndel), 32'd22);

    // Back-to-back redirects: the second target wins and stale data never reaches decode.
    step(1'b1, 32'h300);
    step(1'b1, 32'h405);
    chk("b2b flushed inst_valid", 32'(got_v), 32'd0);
    seen = 1'b0;
    nfire = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step(1'b0, 32'h0);
      if (fire_v && nfire == 0) begin
        chk("b2b first req addr", fire_a, 32'h404);
        nfire++;
      end
      if (got_v) begin
        chk("b2b inst_pc", got_pc, 32'h404);
        chk("b2b inst", got_d, mem_word(32'h404));
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL b2b timeout: inst_valid not seen within 8 cycles, required within 8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
